// File: rtl/adder_arb_pkg.sv
// Shared definitions for the two-requester adder arbiter.
//   state_e  : arbiter FSM states
//   NUM_REQ  : number of requesters sharing the adder
//   ID_W     : width of a requester ID
package adder_arb_pkg;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/adder_arbiter_adder.sv
// Combinational ripple adder shared by the arbiter.
//   a_i, b_i     : operands (WIDTH)
//   cin_i        : carry-in
//   z_o          : (a + b + cin) mod 2^WIDTH
//   carry_out_o  : bit WIDTH of the full sum
module Adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] z_o,
    output logic             carry_out_o
);

    logic [WIDTH:0] sum;

    assign sum         = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
    assign z_o         = sum[WIDTH-1:0];
    assign carry_out_o = sum[WIDTH];

endmodule

// File: rtl/adder_arbiter.sv
// Two requesters share one adder; one operation in flight at a time.
// Round-robin grant in IDLE, the adder is evaluated from latched operands
// in CALC, and the result is held in RESP until the consumer takes it.
// Each requester owns a saved carry that it can chain into its next add.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; grants one and latches its operands
// CALC  | adder settles on latched operands; result registered at exit
// RESP  | rsp_valid held with stable result until rsp_ready
//
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   reqN_valid / reqN_ready    : request handshake (ready pulses on grant)
//   reqN_a, reqN_b, reqN_cin   : operands and explicit carry-in
//   reqN_chain                 : use requester N's saved carry as cin
//   rsp_valid / rsp_ready      : response handshake
//   rsp_id, rsp_z, rsp_cout    : owner, sum, carry-out of the result
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req0_chain,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    input  logic             req1_chain,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [ID_W-1:0]  rsp_id,
    output logic [WIDTH-1:0] rsp_z,
    output logic             rsp_cout
);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_q, b_q;
    logic                 cin_q;
    logic [ID_W-1:0]      id_q;
    logic [ID_W-1:0]      last_q;
    logic [NUM_REQ-1:0]   saved_q;
    logic                 rsp_valid_q;
    logic [ID_W-1:0]      rsp_id_q;
    logic [WIDTH-1:0]     rsp_z_q;
    logic                 rsp_cout_q;

    logic                 gnt_valid;
    logic [ID_W-1:0]      gnt_id;
    logic [WIDTH-1:0]     gnt_a, gnt_b;
    logic                 gnt_cin;
    logic [WIDTH-1:0]     add_z;
    logic                 add_cout;

    always_comb begin
        state_d   = state_q;
        gnt_valid = 1'b0;
        gnt_id    = '0;
        case (state_q)
            ST_IDLE: begin
                // rst_n gating keeps ready low while reset is held
                if (rst_n && (req0_valid || req1_valid)) begin
                    gnt_valid = 1'b1;
                    if (req0_valid && req1_valid) gnt_id = ~last_q;
                    else                          gnt_id = req1_valid;
                    state_d   = ST_CALC;
                end
            end
            ST_CALC: state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt_a   = req0_a;
        gnt_b   = req0_b;
        gnt_cin = req0_chain ? saved_q[0] : req0_cin;
        if (gnt_id == 1'b1) begin
            gnt_a   = req1_a;
            gnt_b   = req1_b;
            gnt_cin = req1_chain ? saved_q[1] : req1_cin;
        end
    end

    assign req0_ready = gnt_valid && (gnt_id == 1'b0);
    assign req1_ready = gnt_valid && (gnt_id == 1'b1);

    Adder #(.WIDTH(WIDTH)) u_adder (
        .a_i         (a_q),
        .b_i         (b_q),
        .cin_i       (cin_q),
        .z_o         (add_z),
        .carry_out_o (add_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            id_q        <= '0;
            last_q      <= 1'b1;  // requester 0 wins the first contention
            saved_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_z_q     <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (gnt_valid) begin
                a_q    <= gnt_a;
                b_q    <= gnt_b;
                cin_q  <= gnt_cin;
                id_q   <= gnt_id;
                last_q <= gnt_id;
            end
            if (state_q == ST_CALC) begin
                rsp_valid_q    <= 1'b1;
                rsp_id_q       <= id_q;
                rsp_z_q        <= add_z;
                rsp_cout_q     <= add_cout;
                saved_q[id_q]  <= add_cout;
            end
            if (state_q == ST_RESP && rsp_ready) rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_z     = rsp_z_q;
    assign rsp_cout  = rsp_cout_q;

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready, req0_cin, req0_chain;
    logic [7:0] req0_a, req0_b;
    logic       req1_valid, req1_ready, req1_cin, req1_chain;
    logic [7:0] req1_a, req1_b;
    logic       rsp_valid, rsp_ready, rsp_cout;
    logic [0:0] rsp_id;
    logic [7:0] rsp_z;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    adder_arbiter #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req0_chain (req0_chain),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .req1_chain (req1_chain),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_z      (rsp_z),
        .rsp_cout   (rsp_cout)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic id, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic chain);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin; req1_chain = chain;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin; req0_chain = chain;
        end
    endtask

    // Called at a negedge with the DUT idle; runs one full transaction.
    task automatic do_op(input string tag, input logic id, input logic [7:0] a,
                         input logic [7:0] b, input logic cin, input logic chain,
                         input logic [7:0] ez, input logic ec);
        drive(id, a, b, cin, chain);
        #1;
        chk({tag, "_ready0"}, req0_ready, !id);
        chk({tag, "_ready1"}, req1_ready, id);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk({tag, "_calc_vld"}, rsp_valid, 1'b0);
        chk({tag, "_calc_rdy"}, {req0_ready, req1_ready}, 2'b00);
        @(negedge clk);
        chk({tag, "_vld"}, rsp_valid, 1'b1);
        chk({tag, "_z"}, rsp_z, ez);
        chk({tag, "_cout"}, rsp_cout, ec);
        chk({tag, "_id"}, rsp_id, id);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_done"}, rsp_valid, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_cin = 1'b0; req0_chain = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0; req1_chain = 1'b0;
        rsp_ready = 1'b0;

        // reset state (valid held high during reset must not be granted)
        @(negedge clk);
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_vld", rsp_valid, 1'b0);
        chk("rst_id", rsp_id, 1'b0);
        chk("rst_z", rsp_z, 8'h00);
        chk("rst_cout", rsp_cout, 1'b0);
        req0_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        do_op("single", 1'b0, 8'h3C, 8'h05, 1'b1, 1'b0, 8'h42, 1'b0);
        do_op("wrap",   1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        do_op("chain1", 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0);
        // req0 sets its own carry; req1's saved carry (0 from chain1) is untouched
        do_op("c0set",  1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        do_op("iso1",   1'b1, 8'h01, 8'h01, 1'b0, 1'b1, 8'h02, 1'b0);
        do_op("chain0", 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h01, 1'b0);

        // backpressure: 0x80+0x80+1 = 0x101
        drive(1'b0, 8'h80, 8'h80, 1'b1, 1'b0);
        #1;
        chk("bp_ready0", req0_ready, 1'b1);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld", rsp_valid, 1'b1);
            chk("bp_z", rsp_z, 8'h01);
            chk("bp_cout", rsp_cout, 1'b1);
            chk("bp_id", rsp_id, 1'b0);
            chk("bp_rdy", {req0_ready, req1_ready}, 2'b00);
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_done", rsp_valid, 1'b0);
        chk("bp_idle_rdy", {req0_ready, req1_ready}, 2'b00);

        // reset during CALC: saved_carry[0] is 1 at this point
        drive(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0);
        #1;
        chk("mid_ready1", req1_ready, 1'b1);
        @(negedge clk);
        req1_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("mid_vld", rsp_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_noresp", rsp_valid, 1'b0);
            chk("mid_z", rsp_z, 8'h00);
        end
        do_op("rst_sc0", 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0);
        do_op("rst_sc1", 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0);

        // contention: last grant was req1, so order is 0,1,0,1
        drive(1'b0, 8'h10, 8'h01, 1'b0, 1'b0);
        drive(1'b1, 8'h20, 8'h02, 1'b0, 1'b0);
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_ready0", req0_ready, (k % 2) == 0);
            chk("rr_ready1", req1_ready, (k % 2) == 1);
            @(negedge clk);
            @(negedge clk);
            chk("rr_vld", rsp_valid, 1'b1);
            chk("rr_id", rsp_id, (k % 2) == 1);
            chk("rr_z", rsp_z, ((k % 2) == 1) ? 8'h22 : 8'h11);
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
